// File: rtl/cpu_mdu_arbiter_if.sv
// Bundle between the two CPU requesters, the arbiter and the shared MDU.
// The arbiter connects through the slave modport. The requester/MDU side connects through the master modport.
interface cpu_mdu_arbiter_if #(
    parameter int XLEN = 32
);
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [2:0]      req_op0;
    logic [2:0]      req_op1;
    logic [XLEN-1:0] req_a0;
    logic [XLEN-1:0] req_b0;
    logic [XLEN-1:0] req_a1;
    logic [XLEN-1:0] req_b1;
    logic [1:0]      rsp_valid;
    logic [1:0]      rsp_ready;
    logic [XLEN-1:0] rsp_result;
    logic            rsp_err;
    logic [XLEN-1:0] mdu_operand_a;
    logic [XLEN-1:0] mdu_operand_b;
    logic [2:0]      mdu_control;
    logic            mdu_start;
    logic [XLEN-1:0] mdu_result;
    logic            mdu_ready;

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        input  rsp_ready, mdu_result, mdu_ready,
        output req_ready, rsp_valid, rsp_result, rsp_err,
        output mdu_operand_a, mdu_operand_b, mdu_control, mdu_start
    );

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_b0, req_a1, req_b1,
        output rsp_ready, mdu_result, mdu_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_err,
        input  mdu_operand_a, mdu_operand_b, mdu_control, mdu_start
    );
endinterface

// File: rtl/cpu_mdu_arbiter.sv
// Two-requester arbiter for a shared multiply/divide unit.
// The arbiter grants one request at a time, alternating when both requesters are pending.
// It issues a single start pulse to the MDU and then waits, bounded by TIMEOUT cycles.
// It returns the result, or a timeout abort, to the granted requester only.
module cpu_mdu_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 reset_n,
    cpu_mdu_arbiter_if.slave     bus,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } stateType;

    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    stateType        r_state;
    stateType        w_nextState;
    logic            r_lastGrant;
    logic            r_grant;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;
    logic            r_err;
    logic [7:0]      r_count;

    logic            w_anyValid;
    logic            w_grantSel;
    logic            w_timeoutHit;
    logic [1:0]      w_reqReady;
    logic [1:0]      w_rspValid;
    logic            w_mduStart;

    assign w_anyValid   = |bus.req_valid;
    assign w_grantSel   = (bus.req_valid == 2'b11) ? ~r_lastGrant : bus.req_valid[1];
    assign w_timeoutHit = (r_count == TimeoutLast);

    // State register; reset abandons any op in flight without a response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and handshake strobes; req_ready is gated by reset_n so nothing is offered while reset is held
    always_comb begin
        w_nextState = r_state;
        w_reqReady  = 2'b00;
        w_rspValid  = 2'b00;
        w_mduStart  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_anyValid && reset_n) begin
                    w_reqReady[w_grantSel] = 1'b1;
                    w_nextState            = ISSUE;
                end
            end
            ISSUE: begin
                w_mduStart  = 1'b1;
                w_nextState = WAIT;
            end
            WAIT: begin
                if (bus.mdu_ready || w_timeoutHit) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                w_rspValid[r_grant] = 1'b1;
                if (bus.rsp_ready[r_grant]) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath registers: request latch, wait counter, result/error capture and fairness pointer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lastGrant <= 1'b1;
            r_grant     <= 1'b0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_count     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_anyValid) begin
                        r_grant <= w_grantSel;
                        r_op    <= w_grantSel ? bus.req_op1 : bus.req_op0;
                        r_a     <= w_grantSel ? bus.req_a1  : bus.req_a0;
                        r_b     <= w_grantSel ? bus.req_b1  : bus.req_b0;
                    end
                end
                ISSUE: begin
                    r_count <= '0;
                end
                WAIT: begin
                    if (bus.mdu_ready) begin
                        r_result <= bus.mdu_result;
                        r_err    <= 1'b0;
                    end else if (w_timeoutHit) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_count <= r_count + 8'd1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready[r_grant]) begin
                        r_lastGrant <= r_grant;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    assign bus.req_ready     = w_reqReady;
    assign bus.rsp_valid     = w_rspValid;
    assign bus.rsp_result    = r_result;
    assign bus.rsp_err       = r_err;
    assign bus.mdu_operand_a = r_a;
    assign bus.mdu_operand_b = r_b;
    assign bus.mdu_control   = r_op;
    assign bus.mdu_start     = w_mduStart;
    assign busy              = (r_state != IDLE);

endmodule

// File: tb/tb_cpu_mdu_arbiter.sv
// Directed bench for cpu_mdu_arbiter with a small behavioural MDU (fixed latency, can be silenced).
module tb_cpu_mdu_arbiter;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 8;
    localparam int MDU_LAT = 2;

    logic clk = 1'b0;
    logic reset_n;
    logic busy;

    int checkCount = 0;
    int passCount  = 0;
    int startCount = 0;
    int strayCount = 0;
    bit mduEnable  = 1'b1;

    cpu_mdu_arbiter_if #(.XLEN(XLEN)) bus ();

    cpu_mdu_arbiter #(
        .XLEN    (XLEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Counts one comparison and reports it when the observed value differs from the expected one
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Advances to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises a request on one channel with the given op and operands
    task automatic applyStimulus(input int idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (idx == 0) begin
            bus.req_op0      = op;
            bus.req_a0       = a;
            bus.req_b0       = b;
            bus.req_valid[0] = 1'b1;
        end else begin
            bus.req_op1      = op;
            bus.req_a1       = a;
            bus.req_b1       = b;
            bus.req_valid[1] = 1'b1;
        end
    endtask

    // Waits a bounded number of cycles for any response
    task automatic waitResponse(input string tag);
        int n;
        n = 0;
        while (bus.rsp_valid == 2'b00 && n < 50) begin
            tick();
            n++;
        end
        checkOutput({tag, "_rsp_arrives"}, 64'(bus.rsp_valid != 2'b00), 64'd1);
    endtask

    // Accepts the pending response on one channel
    task automatic finishResponse(input int idx);
        bus.rsp_ready[idx] = 1'b1;
        tick();
        bus.rsp_ready = 2'b00;
    endtask

    task automatic doReset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    function automatic logic [31:0] mduCompute(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd4:    return (b == 0) ? 32'hFFFF_FFFF : 32'($signed(a) / $signed(b));
            3'd5:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6:    return (b == 0) ? a : 32'($signed(a) % $signed(b));
            3'd7:    return (b == 0) ? a : a % b;
            default: return a * b;
        endcase
    endfunction

    // Behavioural MDU: answers MDU_LAT cycles after a start, and emits a stray ready pulse on request
    initial begin : mduModel
        int          pend;
        int          served;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        pend           = 0;
        served         = 0;
        op             = '0;
        a              = '0;
        b              = '0;
        bus.mdu_ready  = 1'b0;
        bus.mdu_result = '0;
        forever begin
            tick();
            bus.mdu_ready = 1'b0;
            if (!reset_n) begin
                pend = 0;
            end else if (bus.mdu_start) begin
                startCount++;
                op   = bus.mdu_control;
                a    = bus.mdu_operand_a;
                b    = bus.mdu_operand_b;
                pend = MDU_LAT;
            end else if (pend > 0) begin
                pend--;
                if (pend == 0 && mduEnable) begin
                    bus.mdu_ready  = 1'b1;
                    bus.mdu_result = mduCompute(op, a, b);
                end
            end else if (strayCount != served) begin
                served         = strayCount;
                bus.mdu_ready  = 1'b1;
                bus.mdu_result = 32'hDEAD_BEEF;
            end
        end
    end

    // Hard stop in case something hangs outside the bounded waits
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios
    initial begin
        int            s0;
        int            n;
        int            k;
        int            badV;
        int            badR;
        int            badQ;
        int            badS;
        logic [1:0]    grants [4];

        reset_n       = 1'b0;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        bus.req_op0   = '0;
        bus.req_op1   = '0;
        bus.req_a0    = '0;
        bus.req_b0    = '0;
        bus.req_a1    = '0;
        bus.req_b1    = '0;
        for (int i = 0; i < 4; i++) grants[i] = 2'b00;

        // Reset state, with both requests pending to show nothing is accepted
        tick();
        tick();
        checkOutput("rst_busy",      64'(busy),              64'd0);
        checkOutput("rst_req_ready", 64'(bus.req_ready),     64'd0);
        checkOutput("rst_rsp_valid", 64'(bus.rsp_valid),     64'd0);
        checkOutput("rst_mdu_start", 64'(bus.mdu_start),     64'd0);
        checkOutput("rst_result",    64'(bus.rsp_result),    64'd0);
        checkOutput("rst_err",       64'(bus.rsp_err),       64'd0);
        checkOutput("rst_opa",       64'(bus.mdu_operand_a), 64'd0);
        checkOutput("rst_opb",       64'(bus.mdu_operand_b), 64'd0);
        checkOutput("rst_ctrl",      64'(bus.mdu_control),   64'd0);
        bus.req_valid = 2'b00;
        reset_n       = 1'b1;
        tick();

        // Single op: MUL 7*6 from requester 0
        applyStimulus(0, 3'd0, 32'd7, 32'd6);
        #1;
        checkOutput("t1_req_ready", 64'(bus.req_ready), 64'd1);
        s0 = startCount;
        tick();
        bus.req_valid[0] = 1'b0;
        checkOutput("t1_issue_start", 64'(bus.mdu_start),     64'd1);
        checkOutput("t1_issue_ctrl",  64'(bus.mdu_control),   64'd0);
        checkOutput("t1_issue_opa",   64'(bus.mdu_operand_a), 64'd7);
        checkOutput("t1_issue_opb",   64'(bus.mdu_operand_b), 64'd6);
        checkOutput("t1_busy",        64'(busy),              64'd1);
        tick();
        checkOutput("t1_wait_start",  64'(bus.mdu_start),     64'd0);
        checkOutput("t1_wait_opa",    64'(bus.mdu_operand_a), 64'd7);
        waitResponse("t1");
        checkOutput("t1_start_count", 64'(startCount - s0),   64'd1);
        checkOutput("t1_rsp_valid",   64'(bus.rsp_valid),     64'd1);
        checkOutput("t1_result",      64'(bus.rsp_result),    64'd42);
        checkOutput("t1_err",         64'(bus.rsp_err),       64'd0);
        finishResponse(0);
        checkOutput("t1_idle_busy",   64'(busy),              64'd0);
        checkOutput("t1_idle_rsp",    64'(bus.rsp_valid),     64'd0);

        // Contention from reset: DIV 100/7 on req0, REMU 100/7 on req1
        doReset();
        applyStimulus(0, 3'd4, 32'd100, 32'd7);
        applyStimulus(1, 3'd7, 32'd100, 32'd7);
        #1;
        checkOutput("t2_first_grant", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid[0] = 1'b0;
        waitResponse("t2a");
        checkOutput("t2a_rsp_valid", 64'(bus.rsp_valid),  64'd1);
        checkOutput("t2a_result",    64'(bus.rsp_result), 64'd14);
        checkOutput("t2_no_grant_in_resp", 64'(bus.req_ready), 64'd0);
        finishResponse(0);
        checkOutput("t2_second_grant", 64'(bus.req_ready), 64'd2);
        tick();
        bus.req_valid[1] = 1'b0;
        waitResponse("t2b");
        checkOutput("t2b_rsp_valid", 64'(bus.rsp_valid),  64'd2);
        checkOutput("t2b_result",    64'(bus.rsp_result), 64'd2);
        checkOutput("t2b_err",       64'(bus.rsp_err),    64'd0);
        finishResponse(1);

        // Fairness: both held valid for four ops; last grant was requester 1
        applyStimulus(0, 3'd0, 32'd3, 32'd4);
        applyStimulus(1, 3'd0, 32'd5, 32'd5);
        bus.rsp_ready = 2'b11;
        #1;
        k = 0;
        n = 0;
        while (k < 4 && n < 200) begin
            if (bus.req_ready != 2'b00) begin
                grants[k] = bus.req_ready;
                k++;
            end
            tick();
            n++;
        end
        bus.req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t3_grant%0d", i), 64'(grants[i]), (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        n = 0;
        while (busy && n < 50) begin
            tick();
            n++;
        end
        bus.rsp_ready = 2'b00;
        checkOutput("t3_drained", 64'(busy), 64'd0);

        // Backpressure: response to req0 stalled 10 cycles while req1 waits and a stray MDU ready arrives
        applyStimulus(0, 3'd0, 32'd9, 32'd9);
        #1;
        tick();
        bus.req_valid[0] = 1'b0;
        applyStimulus(1, 3'd0, 32'd1, 32'd1);
        waitResponse("t4");
        checkOutput("t4_rsp_valid", 64'(bus.rsp_valid),  64'd1);
        checkOutput("t4_result",    64'(bus.rsp_result), 64'd81);
        bus.rsp_ready = 2'b10;
        strayCount++;
        badV = 0;
        badR = 0;
        badQ = 0;
        badS = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.rsp_valid != 2'b01)       badV++;
            if (bus.rsp_result != 32'd81)     badR++;
            if (bus.req_ready != 2'b00)       badQ++;
            if (bus.mdu_start)                badS++;
        end
        checkOutput("t4_stall_valid",  64'(badV), 64'd0);
        checkOutput("t4_stall_result", 64'(badR), 64'd0);
        checkOutput("t4_stall_ready",  64'(badQ), 64'd0);
        checkOutput("t4_stall_start",  64'(badS), 64'd0);
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        finishResponse(0);
        checkOutput("t4_released", 64'(busy), 64'd0);

        // Timeout: silent MDU, expect exactly TIMEOUT wait cycles then an error response
        mduEnable = 1'b0;
        applyStimulus(0, 3'd0, 32'd2, 32'd3);
        #1;
        tick();
        bus.req_valid[0] = 1'b0;
        checkOutput("t5_issue", 64'(bus.mdu_start), 64'd1);
        n = 0;
        tick();
        while (bus.rsp_valid == 2'b00 && n < 40) begin
            n++;
            tick();
        end
        checkOutput("t5_wait_cycles", 64'(n),              64'd8);
        checkOutput("t5_rsp_valid",   64'(bus.rsp_valid),  64'd1);
        checkOutput("t5_result",      64'(bus.rsp_result), 64'd0);
        checkOutput("t5_err",         64'(bus.rsp_err),    64'd1);
        finishResponse(0);

        // Reset mid-WAIT, then a stray MDU ready after reset release
        applyStimulus(0, 3'd0, 32'd11, 32'd3);
        #1;
        tick();
        bus.req_valid[0] = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("t6_in_wait", 64'(busy), 64'd1);
        reset_n = 1'b0;
        tick();
        reset_n   = 1'b1;
        mduEnable = 1'b1;
        strayCount++;
        badV = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.rsp_valid != 2'b00 || busy) badV++;
        end
        checkOutput("t6_quiet",  64'(badV),           64'd0);
        checkOutput("t6_result", 64'(bus.rsp_result), 64'd0);
        checkOutput("t6_err",    64'(bus.rsp_err),    64'd0);
        applyStimulus(0, 3'd0, 32'd11, 32'd3);
        #1;
        checkOutput("t6_req_ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid[0] = 1'b0;
        waitResponse("t6");
        checkOutput("t6_rsp_valid",  64'(bus.rsp_valid),  64'd1);
        checkOutput("t6_new_result", 64'(bus.rsp_result), 64'd33);
        checkOutput("t6_new_err",    64'(bus.rsp_err),    64'd0);
        finishResponse(0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
